// File: rtl/music_box_if.sv
// -----------------------------------------------------------------------------
// music_box_if
// Bundles the control, song-ROM and note-enable signals of the music box
// sequencer. Clock and reset are not part of the bundle.
//
//   start    level, begin playback from address 0 when idle
//   stop     level, abort playback
//   loop     restart at address 0 instead of finishing (sampled at end-of-song)
//   rom_addr song ROM address (sequencer -> ROM)
//   rom_data registered ROM word, valid one clock after rom_addr
//   note_out note enables, bit0=C ... bit6=B, bit7=C1
//   busy     high whenever the sequencer is not idle
//   done     one-cycle pulse on normal end-of-song
//
// Modports: master = controller/ROM side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface music_box_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              stop;
    logic              loop;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [7:0]        note_out;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, loop, rom_data,
        input  rom_addr, note_out, busy, done
    );

    modport slave (
        input  start, stop, loop, rom_data,
        output rom_addr, note_out, busy, done
    );
endinterface

// File: rtl/music_box_sequencer.sv
// -----------------------------------------------------------------------------
// music_box_sequencer
// Walks a song table in an external synchronous ROM and drives the eight
// note-enable lines of the square-wave synthesis block. Each ROM word is
// {eos[15], note_mask[14:7], duration_ticks[6:0]}; a beat tick is TICK_DIV
// clock cycles.
//
// Ports:
//   clock  system clock
//   reset  synchronous, active-high reset
//   bus    music_box_if.slave (start/stop/loop in, rom_addr out, rom_data in,
//          note_out/busy/done out)
//
// Parameters: ADDR_W (song ROM address width), TICK_DIV (cycles per tick, >=2)
//
// Optional feature: define MUSIC_BOX_GAP_EN to silence note_out during the
// final tick of every entry lasting two or more ticks.
// -----------------------------------------------------------------------------
module music_box_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int TICK_DIV = 2500000
) (
    input  logic       clock,
    input  logic       reset,
    music_box_if.slave bus
);
    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr,  w_addr_nxt;
    logic [7:0]        r_note,  w_note_nxt;
    logic              r_done,  w_done_nxt;
    logic [6:0]        r_dur,   w_dur_nxt;
    logic [TICK_W-1:0] r_tick,  w_tick_nxt;

    logic              w_eos;
    logic [7:0]        w_mask;
    logic [6:0]        w_dur;

    assign w_eos  = bus.rom_data[15];
    assign w_mask = bus.rom_data[14:7];
    assign w_dur  = bus.rom_data[6:0];

    // busy is decoded from the state register only, so it stays registered.
    assign bus.rom_addr = r_addr;
    assign bus.note_out = r_note;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned; that is what keeps it free of latches.
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_note_nxt  = r_note;
        w_done_nxt  = 1'b0;
        w_dur_nxt   = r_dur;
        w_tick_nxt  = r_tick;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            // rom_addr is on the ROM's input; its word is ready next cycle.
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (w_eos) begin
                    if (bus.loop) begin
                        w_addr_nxt  = '0;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_note_nxt  = 8'h00;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_dur == 7'd0) begin
                    // Zero-length entry: skip it without touching note_out.
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_state_nxt = S_FETCH;
                end else begin
                    w_note_nxt  = w_mask;
                    w_dur_nxt   = w_dur;
                    w_tick_nxt  = '0;
                    w_state_nxt = S_PLAY;
                end
            end
            S_PLAY: begin
                if (r_tick == TICK_LAST) begin
                    w_tick_nxt = '0;
                    w_dur_nxt  = r_dur - 7'd1;
                    if (r_dur == 7'd1) begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = S_FETCH;
                    end
`ifdef MUSIC_BOX_GAP_EN
                    // Entering the last tick of a multi-tick entry: go silent
                    // so back-to-back identical notes are heard separately.
                    if (r_dur == 7'd2) begin
                        w_note_nxt = 8'h00;
                    end
`else
`endif
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // stop overrides everything above, including start and end-of-song.
        // rom_addr is left where it was.
        if (bus.stop) begin
            w_state_nxt = S_IDLE;
            w_addr_nxt  = r_addr;
            w_note_nxt  = 8'h00;
            w_done_nxt  = 1'b0;
            w_dur_nxt   = '0;
            w_tick_nxt  = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_note  <= 8'h00;
            r_done  <= 1'b0;
            r_dur   <= '0;
            r_tick  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_note  <= w_note_nxt;
            r_done  <= w_done_nxt;
            r_dur   <= w_dur_nxt;
            r_tick  <= w_tick_nxt;
        end
    end
endmodule

// File: tb/tb_music_box_sequencer.sv
// -----------------------------------------------------------------------------
// tb_music_box_sequencer
// Plays directed and random songs through music_box_sequencer (TICK_DIV=4,
// ADDR_W=4) and compares every output, every cycle, against a per-cycle trace
// derived from the song table: each entry costs 2 fetch cycles plus
// duration*TICK_DIV playing cycles, zero-length entries cost 2, end-of-song
// either restarts at 0 or ends with a done pulse.
// -----------------------------------------------------------------------------
module tb_music_box_sequencer;
    localparam int ADDR_W   = 4;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 1 << ADDR_W;
`ifdef MUSIC_BOX_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [15:0]       rom [DEPTH];
    logic [7:0]        q_note [$];
    logic              q_busy [$];
    logic              q_done [$];
    logic [ADDR_W-1:0] q_addr [$];

    music_box_if #(.ADDR_W(ADDR_W)) bus ();

    music_box_sequencer #(
        .ADDR_W   (ADDR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Synchronous song ROM: word valid one clock after the address.
    always @(posedge clock) bus.rom_data <= rom[bus.rom_addr];

    task automatic check(input string tag, input int cyc,
                         input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] n, input logic b, input logic d, input int a);
        q_note.push_back(n);
        q_busy.push_back(b);
        q_done.push_back(d);
        q_addr.push_back(ADDR_W'(a));
    endtask

    // Expected outputs for cycles 0..len-1 after the start edge.
    task automatic build_trace(input bit lp, input int len);
        int          a;
        int          d;
        logic [7:0]  note;
        logic [15:0] w;
        q_note.delete();
        q_busy.delete();
        q_done.delete();
        q_addr.delete();
        a    = 0;
        note = 8'h00;
        while (q_note.size() < len) begin
            push(note, 1'b1, 1'b0, a);
            push(note, 1'b1, 1'b0, a);
            w = rom[a];
            d = int'(w[6:0]);
            if (w[15]) begin
                if (lp) begin
                    a = 0;
                end else begin
                    push(8'h00, 1'b0, 1'b1, a);
                    while (q_note.size() < len) push(8'h00, 1'b0, 1'b0, a);
                end
            end else if (d == 0) begin
                a = (a + 1) % DEPTH;
            end else begin
                for (int c = 0; c < d * TICK_DIV; c++)
                    push((GAP && d >= 2 && c >= (d - 1) * TICK_DIV) ? 8'h00 : w[14:7],
                         1'b1, 1'b0, a);
                note = (GAP && d >= 2) ? 8'h00 : w[14:7];
                a    = (a + 1) % DEPTH;
            end
        end
    endtask

    // Start a song, compare len cycles, optionally assert stop so that it is
    // seen at edge k+stop_at, hold start for 'hold' edges (ignored while busy).
    task automatic run_song(input bit lp, input int len, input int stop_at, input int hold);
        logic [ADDR_W-1:0] stop_addr;
        stop_addr = '0;
        build_trace(lp, len);
        @(negedge clock);
        bus.loop  = lp;
        bus.start = 1'b1;
        @(posedge clock);
        for (int j = 0; j < len; j++) begin
            @(negedge clock);
            bus.start = (j + 1 < hold);
            if (stop_at >= 0 && j >= stop_at) begin
                check("stop_note", j, 16'(bus.note_out), 16'h0);
                check("stop_busy", j, 16'(bus.busy), 16'h0);
                check("stop_done", j, 16'(bus.done), 16'h0);
                check("stop_addr", j, 16'(bus.rom_addr), 16'(stop_addr));
                if (j == stop_at) bus.stop = 1'b0;
            end else begin
                check("note", j, 16'(bus.note_out), 16'(q_note[j]));
                check("busy", j, 16'(bus.busy), 16'(q_busy[j]));
                check("done", j, 16'(bus.done), 16'(q_done[j]));
                check("addr", j, 16'(bus.rom_addr), 16'(q_addr[j]));
            end
            if (j == stop_at - 1) begin
                bus.stop  = 1'b1;
                stop_addr = q_addr[j];
            end
        end
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        check("end_idle_busy", len, 16'(bus.busy), 16'h0);
    endtask

    initial begin
        bus.start = 1'b1;
        bus.stop  = 1'b0;
        bus.loop  = 1'b0;
        for (int i = 0; i < DEPTH; i++) rom[i] = 16'h8000;

        // Reset with start held high: outputs stay at reset values.
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            @(negedge clock);
            check("rst_note", c, 16'(bus.note_out), 16'h0);
            check("rst_busy", c, 16'(bus.busy), 16'h0);
            check("rst_done", c, 16'(bus.done), 16'h0);
            check("rst_addr", c, 16'(bus.rom_addr), 16'h0);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);

        // One 3-tick note then end-of-song.
        rom[0] = {1'b0, 8'h01, 7'd3};
        rom[1] = 16'h8000;
        run_song(1'b0, 24, -1, 1);
        // Same song looping; start held for a second edge while busy.
        run_song(1'b1, 40, -1, 2);

        // stop mid-PLAY, then replay from address 0.
        rom[0] = {1'b0, 8'h81, 7'd3};
        run_song(1'b0, 20, 7, 1);
        run_song(1'b0, 20, -1, 1);

        // Zero-length entry is skipped.
        rom[0] = {1'b0, 8'hFF, 7'd0};
        rom[1] = {1'b0, 8'h04, 7'd1};
        rom[2] = 16'h8000;
        run_song(1'b0, 16, -1, 1);

        // start and stop together in idle: stop wins.
        @(negedge clock);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clock);
        check("start_stop_busy", 0, 16'(bus.busy), 16'h0);
        check("start_stop_note", 0, 16'(bus.note_out), 16'h0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // No eos anywhere: address wraps to 0 and playback continues.
        for (int i = 0; i < DEPTH; i++) rom[i] = {1'b0, 8'(i + 1), 7'd1};
        run_song(1'b0, 110, -1, 1);

        // Random songs.
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                rom[i][15]   = ($urandom_range(0, 7) == 0);
                rom[i][14:7] = 8'($urandom);
                rom[i][6:0]  = 7'($urandom_range(0, 3));
            end
            run_song(1'($urandom_range(0, 1)), 200,
                     ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 60)),
                     int'($urandom_range(1, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
